// File: rtl/leaf_noc_pkg.sv
// Shared definitions for the leaf-router crossbar arbiter.
//   - requester / output-port indices (GPU = 0, spines 1..4)
//   - idle index marker, routing direction encodings
//   - arbiter FSM state enum
//   - route_dest(): maps a requester and its head-of-line destination
//     to an output port, a direction code and a legality flag
package leaf_noc_pkg;

   localparam int NREQ_C = 5;

   localparam logic [2:0] P_GPU = 3'd0;
   localparam logic [2:0] P_SP1 = 3'd1;
   localparam logic [2:0] P_SP2 = 3'd2;
   localparam logic [2:0] P_SP3 = 3'd3;
   localparam logic [2:0] P_SP4 = 3'd4;

   localparam logic [2:0] IDLE_IDX = 3'd7;

   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;
   localparam logic [1:0] DIR_ERR  = 2'b11;

   typedef enum logic [1:0] {IDLE, GRANT, XFER, ERR} arb_state_e;

   typedef struct packed {
      logic       legal;
      logic [2:0] port;
      logic [1:0] dir;
   } route_t;

   // Local-group destinations go down to the GPU port; anything else goes
   // up to spine 1+dest[1:0]. Only the GPU may go up, only spines may go down.
   function automatic route_t route_dest(input logic [2:0] req,
                                         input logic [5:0] dest,
                                         input logic [3:0] group);
      route_t r;
      if (dest[5:2] == group) begin
         r.port  = P_GPU;
         r.legal = (req != P_GPU);
         r.dir   = DIR_DOWN;
      end else begin
         r.port  = P_SP1 + {1'b0, dest[1:0]};
         r.legal = (req == P_GPU);
         r.dir   = DIR_UP;
      end
      if (!r.legal) r.dir = DIR_ERR;
      return r;
   endfunction

endpackage

// File: rtl/leaf_xbar_arbiter_if.sv
// Handshake/status bundle between the requester queues, the crossbar and
// the leaf arbiter.
//   arb_enable        permit new grants
//   req_valid[5]      head beat valid per requester
//   req_dest[30]      6-bit destination per requester (k at [6k+5:6k])
//   out_ready[5]      output-port ready
//   req_pop[5]        one-hot dequeue strobe
//   grant_onehot[5], current_grant[3], out_sel[3], routing_direction[2]
//   busy, pkt_done, route_err, abort
//   grant_count[80]   only when LEAF_ARB_STATS_EN is defined
// Modport slave = arbiter side, master = requester/crossbar side.
interface leaf_xbar_arbiter_if;
   import leaf_noc_pkg::*;

   logic                    arb_enable;
   logic [NREQ_C-1:0]       req_valid;
   logic [6*NREQ_C-1:0]     req_dest;
   logic [NREQ_C-1:0]       out_ready;
   logic [NREQ_C-1:0]       req_pop;
   logic [NREQ_C-1:0]       grant_onehot;
   logic [2:0]              current_grant;
   logic [2:0]              out_sel;
   logic [1:0]              routing_direction;
   logic                    busy;
   logic                    pkt_done;
   logic                    route_err;
   logic                    abort;
`ifdef LEAF_ARB_STATS_EN
   logic [16*NREQ_C-1:0]    grant_count;

   modport slave (
      input  arb_enable, req_valid, req_dest, out_ready,
      output req_pop, grant_onehot, current_grant, out_sel, routing_direction,
             busy, pkt_done, route_err, abort, grant_count
   );
   modport master (
      output arb_enable, req_valid, req_dest, out_ready,
      input  req_pop, grant_onehot, current_grant, out_sel, routing_direction,
             busy, pkt_done, route_err, abort, grant_count
   );
`else
   modport slave (
      input  arb_enable, req_valid, req_dest, out_ready,
      output req_pop, grant_onehot, current_grant, out_sel, routing_direction,
             busy, pkt_done, route_err, abort
   );
   modport master (
      output arb_enable, req_valid, req_dest, out_ready,
      input  req_pop, grant_onehot, current_grant, out_sel, routing_direction,
             busy, pkt_done, route_err, abort
   );
`endif

endinterface

// File: rtl/leaf_xbar_arbiter_rr_pick5.sv
// rr_pick5: combinational 5-way round-robin first-set finder.
//   req_i[5]  request vector
//   ptr_i[3]  starting index 0..4 (search wraps 4 -> 0)
//   vld_o     any request set
//   idx_o[3]  first set index at or after ptr_i
module rr_pick5 (
   input  logic [4:0] req_i,
   input  logic [2:0] ptr_i,
   output logic       vld_o,
   output logic [2:0] idx_o
);

   logic [3:0] sum;
   logic [2:0] cand;

   always_comb begin
      vld_o = 1'b0;
      idx_o = 3'd0;
      sum   = '0;
      cand  = '0;
      // Scan from the farthest offset down so the nearest set bit is the
      // last one written and therefore wins.
      for (int off = 4; off >= 0; off--) begin
         sum  = {1'b0, ptr_i} + 4'(off);
         cand = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
         if (req_i[cand]) begin
            vld_o = 1'b1;
            idx_o = cand;
         end
      end
   end

endmodule

// File: rtl/leaf_xbar_arbiter.sv
// leaf_xbar_arbiter: packet-level round-robin arbiter/sequencer for the
// single-grant leaf crossbar (GPU = requester 0, spines 1..4).
// Ports:
//   clk    clock
//   reset  asynchronous, active-low
//   bus    leaf_xbar_arbiter_if.slave (requests, readiness, pops, status)
// Flow: IDLE picks a requester round-robin and routes its destination,
// GRANT is a one-cycle crossbar setup, XFER moves PKT_BEATS beats (abort
// after STALL_LIMIT stalled cycles), ERR drops one beat of an illegal route.
// Optional: define LEAF_ARB_STATS_EN for per-requester completed-packet
// counters on bus.grant_count.
module leaf_xbar_arbiter
   import leaf_noc_pkg::*;
#(
   parameter int         NREQ        = 5,
   parameter logic [3:0] GROUP_ID    = 4'b0001,
   parameter int         PKT_BEATS   = 4,
   parameter int         STALL_LIMIT = 16
) (
   input logic               clk,
   input logic               reset,
   leaf_xbar_arbiter_if.slave bus
);

   localparam int BW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
   localparam int SW = $clog2(STALL_LIMIT);
   localparam logic [BW-1:0] BEAT_LAST  = BW'(PKT_BEATS - 1);
   localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

   arb_state_e        state_q, state_d;
   logic [2:0]        rr_ptr_q, rr_ptr_d;
   logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
   logic [SW-1:0]     stall_cnt_q, stall_cnt_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [2:0]        cur_q, cur_d;
   logic [2:0]        sel_q, sel_d;
   logic [1:0]        dir_q, dir_d;

   logic              pick_vld;
   logic [2:0]        pick_idx;
   logic [5:0]        pick_dest;
   route_t            rt;
   logic              move;
   logic              pkt_end;
   logic [NREQ-1:0]   pop;
   logic              pkt_done;
   logic              route_err;
   logic              abort;

   rr_pick5 u_pick (
      .req_i (bus.req_valid),
      .ptr_i (rr_ptr_q),
      .vld_o (pick_vld),
      .idx_o (pick_idx)
   );

   always_comb begin
      pick_dest = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (pick_idx == 3'(k)) pick_dest = bus.req_dest[6*k +: 6];
      end
   end

   assign rt = route_dest(pick_idx, pick_dest, GROUP_ID);

   // A beat moves when the granted head is valid and its output is ready.
   assign move = (|(bus.req_valid & grant_q)) & bus.out_ready[sel_q];

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      beat_cnt_d  = beat_cnt_q;
      stall_cnt_d = stall_cnt_q;
      grant_d     = grant_q;
      cur_d       = cur_q;
      sel_d       = sel_q;
      dir_d       = dir_q;
      pop         = '0;
      pkt_done    = 1'b0;
      route_err   = 1'b0;
      abort       = 1'b0;
      pkt_end     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.arb_enable && pick_vld) begin
               grant_d = NREQ'(1) << pick_idx;
               cur_d   = pick_idx;
               sel_d   = rt.port;
               dir_d   = rt.dir;
               state_d = rt.legal ? GRANT : ERR;
            end
         end
         GRANT: begin
            state_d     = XFER;
            beat_cnt_d  = '0;
            stall_cnt_d = '0;
         end
         XFER: begin
            if (move) begin
               pop         = grant_q;
               stall_cnt_d = '0;
               if (beat_cnt_q == BEAT_LAST) begin
                  pkt_done = 1'b1;
                  pkt_end  = 1'b1;
               end else begin
                  beat_cnt_d = beat_cnt_q + BW'(1);
               end
            end else if (stall_cnt_q == STALL_LAST) begin
               abort   = 1'b1;
               pkt_end = 1'b1;
            end else begin
               stall_cnt_d = stall_cnt_q + SW'(1);
            end
         end
         ERR: begin
            // The illegal head beat is discarded so the queue can progress.
            pop       = grant_q;
            route_err = 1'b1;
            pkt_end   = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Every packet exit (done, abort, error) advances fairness past the
      // owner and releases the crossbar on the next cycle.
      if (pkt_end) begin
         state_d     = IDLE;
         rr_ptr_d    = (cur_q == P_SP4) ? P_GPU : cur_q + 3'd1;
         grant_d     = '0;
         cur_d       = IDLE_IDX;
         sel_d       = IDLE_IDX;
         dir_d       = DIR_IDLE;
         beat_cnt_d  = '0;
         stall_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= P_GPU;
         beat_cnt_q  <= '0;
         stall_cnt_q <= '0;
         grant_q     <= '0;
         cur_q       <= IDLE_IDX;
         sel_q       <= IDLE_IDX;
         dir_q       <= DIR_IDLE;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         beat_cnt_q  <= beat_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         grant_q     <= grant_d;
         cur_q       <= cur_d;
         sel_q       <= sel_d;
         dir_q       <= dir_d;
      end
   end

   assign bus.req_pop           = pop;
   assign bus.grant_onehot      = grant_q;
   assign bus.current_grant     = cur_q;
   assign bus.out_sel           = sel_q;
   assign bus.routing_direction = dir_q;
   assign bus.busy              = (state_q != IDLE);
   assign bus.pkt_done          = pkt_done;
   assign bus.route_err         = route_err;
   assign bus.abort             = abort;

`ifdef LEAF_ARB_STATS_EN
   logic [15:0] gcnt_q [NREQ];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NREQ; k++) gcnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            if (pkt_done && grant_q[k] && (gcnt_q[k] != 16'hFFFF))
               gcnt_q[k] <= gcnt_q[k] + 16'd1;
         end
      end
   end

   for (genvar k = 0; k < NREQ; k++) begin : g_gcnt
      assign bus.grant_count[16*k +: 16] = gcnt_q[k];
   end
`endif

endmodule

// File: tb/tb_leaf_xbar_arbiter.sv
// Bench for leaf_xbar_arbiter: table-driven single-packet vectors, directed
// multi-cycle sequences and randomized traffic, all cross-checked each cycle
// against a behavioural reference model.
module tb_leaf_xbar_arbiter;

   localparam int         PKT_BEATS   = 4;
   localparam int         STALL_LIMIT = 16;
   localparam logic [3:0] GROUP_ID    = 4'b0001;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   leaf_xbar_arbiter_if bus ();

   leaf_xbar_arbiter #(
      .NREQ        (5),
      .GROUP_ID    (GROUP_ID),
      .PKT_BEATS   (PKT_BEATS),
      .STALL_LIMIT (STALL_LIMIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: owner -1 means no packet in flight.
   int m_owner, m_port, m_dir, m_beats, m_stall, m_ptr;
   bit m_err, m_setup;

   logic [4:0] o_pop, o_grant;
   logic [2:0] o_cg, o_sel;
   logic [1:0] o_dir;
   logic       o_busy, o_done, o_rerr, o_abort;

   typedef struct {
      logic        en;
      logic [4:0]  valid;
      logic [29:0] dest;
      logic [4:0]  ready;
      logic [4:0]  pop;
      logic [2:0]  cg;
      logic [2:0]  sel;
      logic [1:0]  dir;
      logic        busy;
      logic        done;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_port = 0; m_dir = 0; m_beats = 0; m_stall = 0;
      m_ptr = 0; m_err = 0; m_setup = 0;
   endtask

   function automatic logic [29:0] mkdest(input int k, input logic [5:0] d);
      return 30'(d) << (6 * k);
   endfunction

   // One clock cycle: drive at the falling edge, compare after settling,
   // then advance the model to what the next rising edge should produce.
   task automatic step(input logic rn, input logic en, input logic [4:0] v,
                       input logic [29:0] d, input logic [4:0] r);
      logic [4:0] e_pop, e_grant;
      logic [2:0] e_cg, e_sel;
      logic [1:0] e_dir;
      logic       e_busy, e_done, e_err, e_abort, moved, found, legal;
      int         k, pick;
      logic [5:0] dk;
      @(negedge clk);
      reset          = rn;
      bus.arb_enable = en;
      bus.req_valid  = v;
      bus.req_dest   = d;
      bus.out_ready  = r;
      if (!rn) model_reset();
      #1;
      e_pop = '0; e_done = 0; e_err = 0; e_abort = 0; moved = 0;
      e_grant = '0; e_cg = 3'd7; e_sel = 3'd7; e_dir = 2'd0; e_busy = 0;
      if (m_owner >= 0) begin
         e_grant = 5'(1 << m_owner);
         e_cg    = 3'(m_owner);
         e_sel   = 3'(m_port);
         e_dir   = 2'(m_dir);
         e_busy  = 1;
         if (m_err) begin
            e_pop = 5'(1 << m_owner);
            e_err = 1;
         end else if (!m_setup) begin
            moved   = v[m_owner] && r[m_port];
            e_pop   = moved ? 5'(1 << m_owner) : 5'd0;
            e_done  = moved && (m_beats == PKT_BEATS - 1);
            e_abort = !moved && (m_stall == STALL_LIMIT - 1);
         end
      end
      o_pop = bus.req_pop; o_grant = bus.grant_onehot; o_cg = bus.current_grant;
      o_sel = bus.out_sel; o_dir = bus.routing_direction; o_busy = bus.busy;
      o_done = bus.pkt_done; o_rerr = bus.route_err; o_abort = bus.abort;
      chk("pop", o_pop, e_pop);
      chk("grant_onehot", o_grant, e_grant);
      chk("current_grant", o_cg, e_cg);
      chk("out_sel", o_sel, e_sel);
      chk("direction", o_dir, e_dir);
      chk("busy", o_busy, e_busy);
      chk("pkt_done", o_done, e_done);
      chk("route_err", o_rerr, e_err);
      chk("abort", o_abort, e_abort);
      if (rn) begin
         if (m_owner < 0) begin
            if (en && (v != 5'd0)) begin
               found = 0; pick = 0;
               for (int off = 0; off < 5; off++) begin
                  k = (m_ptr + off) % 5;
                  if (!found && v[k]) begin found = 1; pick = k; end
               end
               dk = d[6*pick +: 6];
               if (dk[5:2] == GROUP_ID) begin
                  m_port = 0; legal = (pick != 0); m_dir = 2;
               end else begin
                  m_port = 1 + int'(dk[1:0]); legal = (pick == 0); m_dir = 1;
               end
               if (!legal) m_dir = 3;
               m_owner = pick; m_err = !legal; m_setup = legal;
            end
         end else if (m_err || e_done || e_abort) begin
            m_ptr = (m_owner + 1) % 5;
            m_owner = -1; m_err = 0; m_setup = 0; m_beats = 0; m_stall = 0;
         end else if (m_setup) begin
            m_setup = 0; m_beats = 0; m_stall = 0;
         end else if (moved) begin
            m_beats++; m_stall = 0;
         end else begin
            m_stall++;
         end
      end
   endtask

   initial begin
      logic [29:0] dsp;
      logic [4:0]  v, r;
      logic        en;
      logic [3:0]  g4;

      bus.arb_enable = 0; bus.req_valid = '0; bus.req_dest = '0; bus.out_ready = '0;
      model_reset();
      #1 reset = 1'b0;

      // Reset state
      step(0, 0, 5'd0, 30'd0, 5'd0);
      chk("rst_current_grant", o_cg, 3'd7);
      chk("rst_out_sel", o_sel, 3'd7);
      chk("rst_grant", o_grant, 5'd0);
      chk("rst_busy", o_busy, 1'b0);
      step(1, 0, 5'd0, 30'd0, 5'h1f);

      // Single GPU packet, dest 0010_10 -> spine port 3, direction up
      dsp = mkdest(0, 6'b001010);
      tbl[0] = '{1'b1, 5'b00001, dsp, 5'h1f, 5'b00000, 3'd7, 3'd7, 2'b00, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 5'b00001, dsp, 5'h1f, 5'b00000, 3'd0, 3'd3, 2'b01, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 5'b00001, dsp, 5'h1f, 5'b00001, 3'd0, 3'd3, 2'b01, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 5'b00001, dsp, 5'h1f, 5'b00001, 3'd0, 3'd3, 2'b01, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 5'b00001, dsp, 5'h1f, 5'b00001, 3'd0, 3'd3, 2'b01, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 5'b00001, dsp, 5'h1f, 5'b00001, 3'd0, 3'd3, 2'b01, 1'b1, 1'b1};
      tbl[6] = '{1'b1, 5'b00000, dsp, 5'h1f, 5'b00000, 3'd7, 3'd7, 2'b00, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 5'b00000, dsp, 5'h1f, 5'b00000, 3'd7, 3'd7, 2'b00, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         step(1, tbl[i].en, tbl[i].valid, tbl[i].dest, tbl[i].ready);
         chk("t1_pop", o_pop, tbl[i].pop);
         chk("t1_current_grant", o_cg, tbl[i].cg);
         chk("t1_out_sel", o_sel, tbl[i].sel);
         chk("t1_direction", o_dir, tbl[i].dir);
         chk("t1_busy", o_busy, tbl[i].busy);
         chk("t1_pkt_done", o_done, tbl[i].done);
      end

      // Spine-1 packet moves the pointer to 2, then spines 1 and 3 compete
      for (int i = 0; i < 6; i++)
         step(1, 1, 5'b00010, mkdest(1, {GROUP_ID, 2'b00}), 5'h1f);
      step(1, 1, 5'd0, 30'd0, 5'h1f);
      dsp = mkdest(1, {GROUP_ID, 2'b00}) | mkdest(3, {GROUP_ID, 2'b00});
      for (int i = 0; i < 12; i++) begin
         step(1, 1, 5'b01010, dsp, 5'h1f);
         if (i == 1) begin
            chk("t2_first_grant", o_cg, 3'd3);
            chk("t2_first_sel", o_sel, 3'd0);
            chk("t2_first_dir", o_dir, 2'b10);
         end
         if (i == 7) begin
            chk("t2_second_grant", o_cg, 3'd1);
            chk("t2_second_sel", o_sel, 3'd0);
            chk("t2_second_dir", o_dir, 2'b10);
         end
      end
      step(1, 1, 5'd0, 30'd0, 5'h1f);

      // Spine 2 to a remote group is illegal
      for (int i = 0; i < 3; i++) begin
         step(1, 1, (i < 2) ? 5'b00100 : 5'b00000, mkdest(2, 6'b010101), 5'h1f);
         if (i == 1) begin
            chk("t3_err_pop", o_pop, 5'b00100);
            chk("t3_route_err", o_rerr, 1'b1);
            chk("t3_err_dir", o_dir, 2'b11);
         end
         if (i == 2) chk("t3_back_idle", o_busy, 1'b0);
      end

      // GPU to spine port 1 with that port stalled for the full limit
      dsp = mkdest(0, 6'b000000) | mkdest(1, {GROUP_ID, 2'b00});
      for (int i = 0; i < 25; i++) begin
         v = (i < 18) ? 5'b00001 : ((i < 24) ? 5'b00011 : 5'b00000);
         step(1, 1, v, dsp, 5'b11101);
         if (i == 16) chk("t4_abort_early", o_abort, 1'b0);
         if (i == 17) begin
            chk("t4_abort", o_abort, 1'b1);
            chk("t4_no_done", o_done, 1'b0);
         end
         if (i == 19) chk("t4_ptr_after_abort", o_cg, 3'd1);
      end

      // Reset in the second XFER beat, then re-arbitration from pointer 0
      dsp = mkdest(0, 6'b001010) | mkdest(2, {GROUP_ID, 2'b00});
      for (int i = 0; i < 11; i++) begin
         v = (i < 3) ? 5'b00001 : ((i < 10) ? 5'b00101 : 5'b00000);
         step((i == 3) ? 1'b0 : 1'b1, 1, v, dsp, 5'h1f);
         if (i == 3) begin
            chk("t5_rst_pop", o_pop, 5'd0);
            chk("t5_rst_grant", o_cg, 3'd7);
            chk("t5_rst_sel", o_sel, 3'd7);
            chk("t5_rst_busy", o_busy, 1'b0);
         end
         if (i == 5) begin
            chk("t5_regrant", o_cg, 3'd0);
            chk("t5_regrant_sel", o_sel, 3'd3);
         end
      end

      // arb_enable dropped mid-packet
      for (int i = 0; i < 17; i++) begin
         en = !(i >= 2 && i <= 8);
         step(1, en, (i < 15) ? 5'b00001 : 5'b00000, mkdest(0, 6'b001010), 5'h1f);
         if (i == 5) chk("t6_done_while_disabled", o_done, 1'b1);
         if (i == 7) begin
            chk("t6_no_grant_busy", o_busy, 1'b0);
            chk("t6_no_grant_cg", o_cg, 3'd7);
         end
         if (i == 10) begin
            chk("t6_regrant", o_cg, 3'd0);
            chk("t6_regrant_busy", o_busy, 1'b1);
         end
      end

      // Randomized traffic with periodic long stall windows
      for (int n = 0; n < 800; n++) begin
         en  = ($urandom_range(0, 9) != 0);
         v   = 5'($urandom);
         dsp = '0;
         for (int k = 0; k < 5; k++) begin
            if ($urandom_range(0, 4) != 0)
               g4 = (k == 0) ? (GROUP_ID ^ 4'($urandom_range(1, 15))) : GROUP_ID;
            else
               g4 = (k == 0) ? GROUP_ID : (GROUP_ID ^ 4'($urandom_range(1, 15)));
            dsp = dsp | mkdest(k, {g4, 2'($urandom)});
         end
         r = '0;
         for (int k = 0; k < 5; k++) r[k] = ($urandom_range(0, 4) != 0);
         if (((n / 40) % 5) == 4) r = 5'd0;
         step(1, en, v, dsp, r);
      end
      for (int i = 0; i < 3; i++) step(1, 1, 5'd0, 30'd0, 5'h1f);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
